// File: rtl/enc8to3_rr_if.sv
// Handshake bundle between the round-robin encoder and its consumer.
// The master side is the encoder, which issues indices. The slave side requests and accepts them.
interface enc8to3_rr_if;
    logic       en;
    logic [7:0] req;
    logic [2:0] out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;
    logic       busy;

    modport master (
        input  en,
        input  req,
        input  out_ready,
        output out,
        output out_valid,
        output pending,
        output busy
    );

    modport slave (
        output en,
        output req,
        output out_ready,
        input  out,
        input  out_valid,
        input  pending,
        input  busy
    );
endinterface

// File: rtl/enc8to3_rr.sv
// Registered 8:3 round-robin encoder. It latches request pulses and issues them one at a time as 3-bit indices.
// Each issued index is delivered over a valid/ready handshake.
module enc8to3_rr (
    input  logic        clk,
    input  logic        rst_n,
    enc8to3_rr_if.master bus
);
    logic [7:0] pending_reg, pending_next;
    logic [2:0] out_reg, out_next;
    logic       out_valid_reg, out_valid_next;
    logic [2:0] ptr_reg, ptr_next;

    logic [7:0] rotated;
    logic [2:0] offset;
    logic [2:0] sel_idx;
    logic       free;
    logic       issue;

    // rotated[gi] is the pending bit gi positions past the pointer, so the lowest set bit wins.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign rotated[gi] = pending_reg[3'(ptr_reg + 3'(gi))];
        end
    endgenerate

    always_comb begin
        offset = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = 3'(k);
            end
        end
    end

    assign sel_idx = ptr_reg + offset;
    assign free    = !out_valid_reg || bus.out_ready;
    assign issue   = bus.en && free && (pending_reg != 8'd0);

    always_comb begin
        pending_next   = pending_reg;
        out_next       = out_reg;
        out_valid_next = out_valid_reg;
        ptr_next       = ptr_reg;
        if (issue) begin
            pending_next[sel_idx] = 1'b0;
            out_next              = sel_idx;
            out_valid_next        = 1'b1;
            ptr_next              = sel_idx + 3'd1;
        end else if (free) begin
            out_valid_next = 1'b0;
        end
        // Set is applied after clear, so a request that arrives on its own issue cycle is kept.
        if (bus.en) begin
            pending_next = pending_next | bus.req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg   <= 8'd0;
            out_reg       <= 3'd0;
            out_valid_reg <= 1'b0;
            ptr_reg       <= 3'd0;
        end else begin
            pending_reg   <= pending_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            ptr_reg       <= ptr_next;
        end
    end

    assign bus.out       = out_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.pending   = pending_reg;
    assign bus.busy      = (pending_reg != 8'd0) || out_valid_reg;
endmodule

// File: tb/tb_enc8to3_rr.sv
// Self-checking bench for enc8to3_rr. It runs directed scenarios and then random traffic.
// All output is compared against a cycle-level reference model.
module tb_enc8to3_rr;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    enc8to3_rr_if bus_if ();

    enc8to3_rr dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int   m_pending;
    int   m_out;
    bit   m_valid;
    int   m_ptr;

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_edge();
        int  newp;
        bit  free;
        if (!rst_n) begin
            m_pending = 0;
            m_out     = 0;
            m_valid   = 0;
            m_ptr     = 0;
            return;
        end
        newp = m_pending;
        free = !m_valid || bus_if.out_ready;
        if (bus_if.en && free && m_pending != 0) begin
            for (int k = 0; k < 8; k++) begin
                int idx;
                idx = (m_ptr + k) % 8;
                if ((m_pending >> idx) & 1) begin
                    m_out   = idx;
                    m_valid = 1;
                    newp    = newp & ~(1 << idx);
                    m_ptr   = (idx + 1) % 8;
                    break;
                end
            end
        end else if (free) begin
            m_valid = 0;
        end
        if (bus_if.en) newp = newp | int'(bus_if.req);
        m_pending = newp;
    endtask

    // One clock: log any handshake, advance the model with pre-edge inputs, compare just after the edge.
    task automatic step();
        if (rst_n && bus_if.out_valid && bus_if.out_ready)
            $display("t=%0t accept idx=%0d", $time, bus_if.out);
        @(posedge clk);
        model_edge();
        #1;
        check_eq("out_valid", 32'(bus_if.out_valid), 32'(m_valid));
        if (m_valid) check_eq("out", 32'(bus_if.out), 32'(m_out));
        check_eq("pending", 32'(bus_if.pending), 32'(m_pending));
        check_eq("busy", 32'(bus_if.busy), 32'((m_pending != 0) || m_valid));
    endtask

    task automatic drive(input bit e, input logic [7:0] r, input bit rdy);
        bus_if.en        = e;
        bus_if.req       = r;
        bus_if.out_ready = rdy;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 8'hFF, 1);
        m_pending = 0; m_out = 0; m_valid = 0; m_ptr = 0;
        step();
        step();
        check_eq("rst_pending", 32'(bus_if.pending), 32'h0);
        check_eq("rst_valid", 32'(bus_if.out_valid), 32'h0);
        check_eq("rst_out", 32'(bus_if.out), 32'h0);
        check_eq("rst_busy", 32'(bus_if.busy), 32'h0);
        rst_n = 1'b1;

        // Single request on line 5
        drive(1, 8'h20, 1);
        step();
        check_eq("single_capture", 32'(bus_if.pending), 32'h20);
        drive(1, 8'h00, 1);
        step();
        check_eq("single_out", 32'(bus_if.out), 32'd5);
        check_eq("single_valid", 32'(bus_if.out_valid), 32'd1);
        step();
        check_eq("single_drain", 32'(bus_if.out_valid), 32'd0);

        // Full sweep starting from the pointer, which sits at 6 after the index-5 issue
        drive(1, 8'hFF, 1);
        step();
        drive(1, 8'h00, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("sweep_out", 32'(bus_if.out), 32'((6 + i) % 8));
        end
        step();
        check_eq("sweep_drain", 32'(bus_if.out_valid), 32'd0);

        // Pointer is at 6 here. Issue 7 to wrap it to 0, then 0x81 must give 0 then 7
        drive(1, 8'h80, 1); step();
        drive(1, 8'h00, 1); step();
        check_eq("wrap_seed", 32'(bus_if.out), 32'd7);
        step();
        drive(1, 8'h81, 1); step();
        drive(1, 8'h00, 1); step();
        check_eq("wrap_first", 32'(bus_if.out), 32'd0);
        step();
        check_eq("wrap_second", 32'(bus_if.out), 32'd7);
        step();

        // Backpressure holds index 2
        drive(1, 8'h0C, 0); step();
        drive(1, 8'h00, 0); step();
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("bp_hold_out", 32'(bus_if.out), 32'd2);
            check_eq("bp_hold_pend", 32'(bus_if.pending), 32'h08);
        end
        drive(1, 8'h00, 1); step();
        check_eq("bp_release", 32'(bus_if.out), 32'd3);
        step();

        // Set wins over clear. The pointer is at 4, so prime it to 2 by issuing index 1 first
        drive(1, 8'h02, 1); step();
        drive(1, 8'h04, 1); step();
        check_eq("sc_prime", 32'(bus_if.out), 32'd1);
        drive(1, 8'h04, 1); step();
        check_eq("sc_out", 32'(bus_if.out), 32'd2);
        check_eq("sc_pending", 32'(bus_if.pending), 32'h04);
        drive(1, 8'h00, 1); step();
        check_eq("sc_reissue", 32'(bus_if.out), 32'd2);
        step();

        // Enable gating with a held output that is still accepted
        drive(1, 8'h03, 0); step();
        drive(1, 8'h00, 0); step();
        drive(0, 8'h10, 1);
        for (int i = 0; i < 3; i++) step();
        check_eq("en_pending", 32'(bus_if.pending), 32'h02);
        check_eq("en_drained", 32'(bus_if.out_valid), 32'd0);
        drive(1, 8'h00, 1); step();
        check_eq("en_resume", 32'(bus_if.out), 32'd1);
        step();

        // Random traffic with occasional resets
        for (int c = 0; c < 800; c++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            drive(($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                  ($urandom_range(0, 3) != 0));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
